distram_fifo64: RTL and testbench

DISTRAM_FIFO64 -- requirements
Module: distram_fifo64

---
 rtl/distram_fifo64_pkg.sv | 11 +
 rtl/distram64d.sv | 30 +++
 rtl/distram_fifo64.sv | 71 +++++++
 tb/tb_distram_fifo64.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/distram_fifo64_pkg.sv
// Shared sizing constants and pointer helper for the 64-deep distributed-RAM FIFO.
package distram_fifo64_pkg;
    localparam int FIFO64_DEPTH = 64;
    localparam int FIFO64_PTR_W = 6;
    localparam int FIFO64_CNT_W = 7;

    // Pointers are exactly log2(depth) bits wide, so wrap 63->0 is natural overflow.
    function automatic logic [FIFO64_PTR_W-1:0] ptr_inc(input logic [FIFO64_PTR_W-1:0] ptr);
        return ptr + FIFO64_PTR_W'(1);
    endfunction
endpackage

// File: rtl/distram64d.sv
// Simple dual-port 64xWIDTH distributed RAM: one 64x1 slice per data bit,
// synchronous write port, asynchronous read port.
module distram64d
    import distram_fifo64_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [FIFO64_PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [FIFO64_PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]        rd_data
);
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            // Each slice has the shape of a RAM64X1D: shared write address, separate read address.
            logic mem_reg [FIFO64_DEPTH];

            always_ff @(posedge clk) begin
                if (we) begin
                    mem_reg[wr_addr] <= wr_data[gi];
                end
            end

            assign rd_data[gi] = mem_reg[rd_addr];
        end
    endgenerate
endmodule

// File: rtl/distram_fifo64.sv
// 64-word first-word-fall-through FIFO: pointer, count and control logic around
// a distributed RAM with asynchronous read.
module distram_fifo64
    import distram_fifo64_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    wr_en,
    output logic                    wr_ready,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_valid,
    input  logic                    rd_en,
    output logic [FIFO64_CNT_W-1:0] count
);
    logic [FIFO64_PTR_W-1:0] wr_ptr_reg;
    logic [FIFO64_PTR_W-1:0] rd_ptr_reg;
    logic [FIFO64_CNT_W-1:0] count_reg;
    logic [FIFO64_CNT_W-1:0] count_next;
    logic                    push;
    logic                    pop;
    logic                    ram_we;

    // Flags come from the registered count only, so a push into a full FIFO is
    // refused even when a pop happens on the same edge.
    assign wr_ready = (count_reg != FIFO64_CNT_W'(FIFO64_DEPTH));
    assign rd_valid = (count_reg != '0);
    assign push     = wr_en && wr_ready;
    assign pop      = rd_en && rd_valid;
    assign ram_we   = push && !reset && !clear;
    assign count    = count_reg;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + FIFO64_CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - FIFO64_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_next;
        end
    end

    distram64d #(
        .WIDTH(WIDTH)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_distram_fifo64.sv
// Directed and scoreboarded checks for the 64-word FWFT distributed-RAM FIFO.
module tb_distram_fifo64;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_en = 1'b0;
    logic [6:0]  count;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_q[$];

    always #5 clk = ~clk;

    distram_fifo64 #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_en    (rd_en),
        .count    (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pop_word;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        bit          we_b;
        bit          re_b;
        logic [31:0] d;

        // Reset state
        step();
        step();
        reset = 1'b0;
        check("reset_count", 32'(count), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_wr_ready", 32'(wr_ready), 32'd1);
        $display("reset: count=%0d rd_valid=%0d wr_ready=%0d", count, rd_valid, wr_ready);

        // Three consecutive pushes, FWFT latency of one cycle
        wr_en = 1'b1;
        wr_data = 32'h11111111;
        step();
        check("fwft_valid", 32'(rd_valid), 32'd1);
        check("fwft_data", rd_data, 32'h11111111);
        wr_data = 32'h22222222;
        step();
        wr_data = 32'h33333333;
        step();
        wr_en = 1'b0;
        check("three_count", 32'(count), 32'd3);
        check("three_head", rd_data, 32'h11111111);
        $display("push3: count=%0d head=0x%08h", count, rd_data);

        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_count", 32'(count), 32'd0);

        // Fill to 64, reject a 65th write, drain in order
        for (int i = 0; i < 64; i++) push_word(32'(i));
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_count", 32'(count), 32'd64);
        push_word(32'hDEADBEEF);
        check("overflow_count", 32'(count), 32'd64);
        check("overflow_head", rd_data, 32'd0);
        $display("fill64: count=%0d wr_ready=%0d", count, wr_ready);
        for (int i = 0; i < 64; i++) begin
            check("drain_data", rd_data, 32'(i));
            pop_word();
        end
        check("drain_rd_valid", 32'(rd_valid), 32'd0);
        check("drain_count", 32'(count), 32'd0);
        pop_word();
        check("underflow_count", 32'(count), 32'd0);
        $display("drain64: count=%0d rd_valid=%0d", count, rd_valid);

        // Full with simultaneous push and pop
        for (int i = 0; i < 64; i++) push_word(32'(100 + i));
        wr_data = 32'hCAFEF00D;
        wr_en = 1'b1;
        rd_en = 1'b1;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("fullpp_count", 32'(count), 32'd63);
        check("fullpp_head", rd_data, 32'd101);
        check("fullpp_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 1; i < 64; i++) begin
            check("fullpp_drain", rd_data, 32'(100 + i));
            pop_word();
        end
        check("fullpp_empty", 32'(rd_valid), 32'd0);
        $display("full_push_pop: drained, rd_valid=%0d", rd_valid);

        // Empty with simultaneous push and pop
        wr_data = 32'hA5A5A5A5;
        wr_en = 1'b1;
        rd_en = 1'b1;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("emptypp_count", 32'(count), 32'd1);
        check("emptypp_data", rd_data, 32'hA5A5A5A5);
        check("emptypp_valid", 32'(rd_valid), 32'd1);
        $display("empty_push_pop: count=%0d data=0x%08h", count, rd_data);
        pop_word();

        // Randomized traffic against a queue scoreboard
        for (int c = 0; c < 200; c++) begin
            we_b = ($urandom_range(0, 99) < 60);
            re_b = ($urandom_range(0, 99) < 45);
            d = $urandom;
            check("rand_valid", 32'(rd_valid), 32'(model_q.size() != 0));
            check("rand_ready", 32'(wr_ready), 32'(model_q.size() != 64));
            if (model_q.size() != 0) check("rand_head", rd_data, model_q[0]);
            wr_en = we_b;
            rd_en = re_b;
            wr_data = d;
            step();
            if (re_b && model_q.size() != 0) void'(model_q.pop_front());
            else re_b = 1'b0;
            if (we_b && model_q.size() + (re_b ? 1 : 0) != 64) model_q.push_back(d);
            check("rand_count", 32'(count), 32'(model_q.size()));
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        while (model_q.size() != 0) begin
            check("rand_drain", rd_data, model_q.pop_front());
            pop_word();
        end
        check("rand_final_count", 32'(count), 32'd0);
        $display("random: 200 cycles done, count=%0d", count);

        // Clear beats simultaneous push and pop
        for (int i = 0; i < 10; i++) push_word(32'(500 + i));
        check("pre_clear_count", 32'(count), 32'd10);
        clear = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 32'h0BADF00D;
        step();
        clear = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("clearpp_count", 32'(count), 32'd0);
        check("clearpp_valid", 32'(rd_valid), 32'd0);
        check("clearpp_ready", 32'(wr_ready), 32'd1);
        $display("clear_priority: count=%0d", count);

        // Reset mid-operation with a write pending
        for (int i = 0; i < 5; i++) push_word(32'(700 + i));
        reset = 1'b1;
        wr_en = 1'b1;
        step();
        reset = 1'b0;
        wr_en = 1'b0;
        check("midreset_count", 32'(count), 32'd0);
        check("midreset_valid", 32'(rd_valid), 32'd0);
        push_word(32'h12345678);
        check("post_reset_head", rd_data, 32'h12345678);
        $display("mid_reset: count after push=%0d", count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
